dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences a single-port data RAM and shares it between two requesters: instruction fetch (read-only) and memory-access stage (read/write).
- Sits between the pipeline stages and the ram instance; owns ram r_en/w_en/addr/wdata.
- Multi-cycle access with req/valid handshake; exports stall signals so the pipeline control can freeze stages.

Parameters:
- ADDR_W, 64, address width (matches ADDR_BUS).
- DATA_W, 64, data width (matches DATA_BUS).
- MEM_LAT, 2, RAM access cycles per transaction; legal range 1..15; elaboration error otherwise.
- AGE_MAX, 4, consecutive memory-stage grants tolerated while fetch waits (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset: one clock; reset is synchronous and active-low.
- if_req_i  in  1  fetch read request; held until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetch read data; meaningful only while if_valid_o.
- if_valid_o  out  1  one-cycle fetch completion pulse.
- if_error_o  out  1  fetch address error; qualified by if_valid_o.
- if_stall_o  out  1  if_req_i & ~if_valid_o.
- m_req_i  in  1  memory-stage request; held until m_valid_o.
- m_we_i  in  1  1 = write, 0 = read.
- m_addr_i  in  ADDR_W  memory-stage address.
- m_wdata_i  in  DATA_W  write data.
- m_rdata_o  out  DATA_W  read data; meaningful only while m_valid_o.
- m_valid_o  out  1  one-cycle memory-stage completion pulse.
- m_error_o  out  1  memory-stage address error; qualified by m_valid_o.
- m_stall_o  out  1  m_req_i & ~m_valid_o.
- ram_r_en_o  out  1  RAM read enable.
- ram_w_en_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data.
- ram_error_i  in  1  RAM address error.

Behaviour:
- Reset (rst_n_i = 0 at a rising edge): state IDLE, lat counter 0, owner FETCH, all registered outputs 0. Any in-flight transaction is abandoned; no valid pulse; a pending write is not performed.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If m_req_i, grant MEM; else if if_req_i, grant FETCH; else stay.
  - On grant: latch owner, addr, we (forced 0 for FETCH) and wdata; cnt <= MEM_LAT-1; go to ACCESS.
  - Simultaneous requests: MEM wins, because it is the older instruction.
- ACCESS:
  - ram_addr_o and ram_wdata_o come from the latches.
  - ram_r_en_o = ~we for every ACCESS cycle.
  - ram_w_en_o = we only in the last ACCESS cycle (cnt == 0), so each write occurs exactly once.
  - cnt decrements each cycle. At cnt == 0: capture ram_rdata_i and ram_error_i into response registers; go to DONE.
- DONE:
  - Owner's valid = 1 for exactly one cycle, with its rdata/error driven from the response registers.
  - Other requester's valid = 0. Next state IDLE.
- Outside ACCESS: all ram_* enables 0, ram_addr_o and ram_wdata_o 0.
- Latency: request sampled at edge t -> ACCESS cycles t+1..t+MEM_LAT -> valid in cycle t+MEM_LAT+1. Throughput: one transaction per MEM_LAT+2 cycles.
- Handshake rules:
  - Request inputs are sampled only in IDLE; changes during ACCESS/DONE are ignored.
  - A requester drops req in the cycle after valid unless it issues a new request.
  - A req still high in the IDLE after DONE is treated as a new transaction.
- Request withdrawn mid-transaction: the transaction still completes (write performed) and valid still pulses.
- rdata on a write transaction: 0.
- The losing requester keeps its stall high throughout; no request is lost.

Optional Feature:
- Macro DMEM_ARB_AGE_EN.
- Defined:
  - An age counter (0..AGE_MAX) increments on each MEM grant made while if_req_i = 1.
  - It clears on any FETCH grant, and in any IDLE cycle where if_req_i = 0.
  - When age == AGE_MAX and both requests are present in IDLE, FETCH wins.
- Undefined: strict MEM priority; fetch may starve; no counter logic.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding (IDLE/ACCESS/DONE, 2 bits).
  - Owner encoding (FETCH = 0, MEM = 1).
  - Counter width constant (4 bits).
- One sub-module, dmem_arb_age: the age counter and its override flag. Instantiated only under DMEM_ARB_AGE_EN.

Test Plan:
1. Reset mid-access: assert rst_n_i = 0 during ACCESS of a write of 0x55 to 0x80 -> no valid pulse; ram_w_en_o never 1; mem[0x80] unchanged.
2. Single read, MEM_LAT = 2: m_req (we = 0, addr 0x100), RAM returns 0xDEADBEEF -> ram_r_en_o high 2 cycles; m_valid_o one cycle at t+3 with m_rdata_o = 0xDEADBEEF; m_stall_o high t..t+2.
3. Single write: m_req (we = 1, addr 0x40, data 0x1234) -> ram_w_en_o exactly 1 cycle (t+2) with addr 0x40 and data 0x1234; m_valid_o at t+3.
4. Simultaneous requests: if_req (0x0) and m_req (0x200) -> MEM served first (valid at t+3); FETCH granted at t+4 with if_valid_o at t+7; if_stall_o high t..t+6.
5. Error: m_req read at out-of-range addr with ram_error_i = 1 -> m_error_o = 1 with m_valid_o. Next transaction completes with m_error_o = 0.
6. DMEM_ARB_AGE_EN, AGE_MAX = 4: continuous m_req plus if_req -> 4 MEM grants, then 1 FETCH grant, repeating. Without the macro: zero FETCH grants over 50 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, owner encoding, counter width.
// Optional macro DMEM_ARB_AGE_EN enables fetch anti-starvation ageing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_MEM   = 1'b1
  } owner_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arb_age.sv
// Fetch ageing: counts MEM grants that bypassed a waiting fetch.
// Raises fetch_pri_o once the limit is reached (DMEM_ARB_AGE_EN only).
module dmem_arb_age
  import dmem_arb_pkg::*;
#(
  parameter int AGE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic m_grant_i,
  input  logic f_grant_i,
  output logic fetch_pri_o
);

  localparam logic [CNT_W-1:0] AGE_LIM = CNT_W'(AGE_MAX);

  logic [CNT_W-1:0] age_q;
  logic [CNT_W-1:0] age_d;

  // next age: clear when fetch served or idle, bump on a bypassing MEM grant
  always_comb begin
    age_d = age_q;
    if (f_grant_i || (idle_i && !if_req_i)) begin
      age_d = '0;
    end else if (m_grant_i && if_req_i && (age_q != AGE_LIM)) begin
      age_d = age_q + 1'b1;
    end
  end

  // age register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) age_q <= '0;
    else          age_q <= age_d;
  end

  assign fetch_pri_o = (age_q == AGE_LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data RAM between fetch (read) and memory stage (read/write).
// Define DMEM_ARB_AGE_EN to stop fetch starving under constant MEM traffic.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2,
  parameter int AGE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_error_o,
  output logic              if_stall_o,
  input  logic              m_req_i,
  input  logic              m_we_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic              m_valid_o,
  output logic              m_error_o,
  output logic              m_stall_o,
  output logic              ram_r_en_o,
  output logic              ram_w_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_error_i
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("dmem_arbiter: MEM_LAT must be 1..15");
  end

  if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_age_chk
    $error("dmem_arbiter: AGE_MAX must be 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic idle, in_acc, in_done;
  logic fetch_pri, grant_m, grant_f;

  assign idle    = (state_q == ST_IDLE);
  assign in_acc  = (state_q == ST_ACCESS);
  assign in_done = (state_q == ST_DONE);

`ifdef DMEM_ARB_AGE_EN
  dmem_arb_age #(
    .AGE_MAX (AGE_MAX)
  ) u_age (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .idle_i      (idle),
    .if_req_i    (if_req_i),
    .m_grant_i   (grant_m),
    .f_grant_i   (grant_f),
    .fetch_pri_o (fetch_pri)
  );
`else
  assign fetch_pri = 1'b0;
`endif

  // MEM is the older instruction, so it wins unless fetch has aged out
  assign grant_m = idle & m_req_i & ~(fetch_pri & if_req_i);
  assign grant_f = idle & if_req_i & ~grant_m;

  // FSM next state, request latching and response capture
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_m) begin
          owner_d = OWN_MEM;
          we_d    = m_we_i;
          addr_d  = m_addr_i;
          wdata_d = m_wdata_i;
          cnt_d   = LAT_INIT;
          state_d = ST_ACCESS;
        end else if (grant_f) begin
          owner_d = OWN_FETCH;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
          cnt_d   = LAT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : ram_rdata_i;
          err_d   = ram_error_i;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any transaction
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_FETCH;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // write strobes only in the last access cycle so it happens once
  assign ram_r_en_o  = in_acc & ~we_q;
  assign ram_w_en_o  = in_acc & we_q & (cnt_q == '0);
  assign ram_addr_o  = in_acc ? addr_q  : '0;
  assign ram_wdata_o = in_acc ? wdata_q : '0;

  assign m_valid_o  = in_done & (owner_q == OWN_MEM);
  assign if_valid_o = in_done & (owner_q == OWN_FETCH);
  assign m_rdata_o  = m_valid_o  ? rdata_q : '0;
  assign if_rdata_o = if_valid_o ? rdata_q : '0;
  assign m_error_o  = m_valid_o  & err_q;
  assign if_error_o = if_valid_o & err_q;
  assign m_stall_o  = m_req_i  & ~m_valid_o;
  assign if_stall_o = if_req_i & ~if_valid_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model.
// Honours DMEM_ARB_AGE_EN for the starvation/ageing scenario.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int LAT = 2;
  localparam int AGE = 4;
`ifdef DMEM_ARB_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        m_req = 1'b0;
  logic        m_we = 1'b0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;

  logic [63:0] if_rdata_o, m_rdata_o;
  logic        if_valid_o, if_error_o, if_stall_o;
  logic        m_valid_o, m_error_o, m_stall_o;
  logic        ram_r_en_o, ram_w_en_o;
  logic [63:0] ram_addr_o, ram_wdata_o;
  logic [63:0] ram_rdata;
  logic        ram_error;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .AGE_MAX(AGE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .if_error_o(if_error_o), .if_stall_o(if_stall_o),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_rdata_o(m_rdata_o),
    .m_valid_o(m_valid_o), .m_error_o(m_error_o),
    .m_stall_o(m_stall_o),
    .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata), .ram_error_i(ram_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mem_load = 1'b1;
  bit chk_on   = 1'b0;

  function automatic logic [63:0] init_word(int i);
    if (i == 32) return 64'hDEAD_BEEF;
    return {32'hC0DE_0000, 32'(i)};
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: 128 words below 0x400, anything above is an address error
  logic [63:0] mem [128];
  assign ram_error = (ram_addr_o >= 64'h400);
  assign ram_rdata = ram_error ? 64'h0 : mem[ram_addr_o[9:3]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
    end else if (ram_w_en_o && !ram_error) begin
      mem[ram_addr_o[9:3]] <= ram_wdata_o;
    end
  end

  // reference model: ph 0 idle, 1..LAT access, LAT+1 response
  int          ph = 0;
  int          age = 0;
  bit          md_mem = 1'b0;
  bit          md_we = 1'b0;
  logic [63:0] md_addr = '0, md_wd = '0, md_rd = '0;
  bit          md_err = 1'b0;
  logic [63:0] mmem [128];

  always @(posedge clk) begin
    bit tm, tf;
    if (mem_load) for (int i = 0; i < 128; i++) mmem[i] = init_word(i);
    if (!rst_n) begin
      ph = 0; age = 0; md_mem = 1'b0; md_rd = '0; md_err = 1'b0;
    end else if (ph == 0) begin
      tm = m_req && !(AGE_EN && age == AGE && if_req);
      tf = if_req && !tm;
      if (tf || !if_req) age = 0;
      else if (tm && age < AGE) age = age + 1;
      if (tm || tf) begin
        md_mem  = tm;
        md_we   = tm && m_we;
        md_addr = tm ? m_addr : if_addr;
        md_wd   = tm ? m_wdata : 64'h0;
        ph = 1;
      end
    end else if (ph <= LAT) begin
      if (ph == LAT) begin
        md_err = (md_addr >= 64'h400);
        if (md_we) begin
          md_rd = 64'h0;
          if (!md_err) mmem[md_addr[9:3]] = md_wd;
        end else begin
          md_rd = md_err ? 64'h0 : mmem[md_addr[9:3]];
        end
      end
      ph++;
    end else begin
      ph = 0;
    end
  end

  int n_wen = 0, n_ren = 0, n_mv = 0, n_fv = 0;
  int n_mst = 0, n_fst = 0;
  int wen_cyc = 0;
  logic [63:0] wen_addr = '0, wen_data = '0;
  bit own_q[$];

  // per-cycle comparison against the model plus event counters
  always @(negedge clk) begin
    bit acc, rsp;
    if (chk_on) begin
      acc = (ph >= 1 && ph <= LAT);
      rsp = (ph == LAT + 1);
      check("ram_r_en", ram_r_en_o, acc && !md_we);
      check("ram_w_en", ram_w_en_o, acc && md_we && ph == LAT);
      check("ram_addr", ram_addr_o, acc ? md_addr : 64'h0);
      check("ram_wdata", ram_wdata_o, acc ? md_wd : 64'h0);
      check("m_valid", m_valid_o, rsp && md_mem);
      check("if_valid", if_valid_o, rsp && !md_mem);
      check("m_stall", m_stall_o, m_req && !(rsp && md_mem));
      check("if_stall", if_stall_o, if_req && !(rsp && !md_mem));
      if (rsp && md_mem) begin
        check("m_rdata", m_rdata_o, md_rd);
        check("m_error", m_error_o, md_err);
      end
      if (rsp && !md_mem) begin
        check("if_rdata", if_rdata_o, md_rd);
        check("if_error", if_error_o, md_err);
      end
    end
    if (ram_w_en_o === 1'b1) begin
      n_wen++; wen_cyc = cyc; wen_addr = ram_addr_o; wen_data = ram_wdata_o;
    end
    if (ram_r_en_o === 1'b1) n_ren++;
    if (m_valid_o === 1'b1) begin n_mv++; own_q.push_back(1'b1); end
    if (if_valid_o === 1'b1) begin n_fv++; own_q.push_back(1'b0); end
    if (m_stall_o === 1'b1) n_mst++;
    if (if_stall_o === 1'b1) n_fst++;
  end

  task automatic mem_txn(input bit we, input logic [63:0] a,
                         input logic [63:0] d, output int tr,
                         output int tv, output logic [63:0] rd,
                         output logic er);
    int k = 0;
    m_we = we; m_addr = a; m_wdata = d; m_req = 1'b1; tr = cyc;
    tv = -1; rd = 'x; er = 1'bx;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (m_valid_o) begin
        tv = cyc; rd = m_rdata_o; er = m_error_o; break;
      end
    end
    if (tv < 0) check("m_timeout", 64'(k), 64'h0);
    @(posedge clk); #1;
    m_req = 1'b0;
  endtask

  task automatic fetch_txn(input logic [63:0] a, output int tr,
                           output int tv, output logic [63:0] rd,
                           output logic er);
    int k = 0;
    if_addr = a; if_req = 1'b1; tr = cyc;
    tv = -1; rd = 'x; er = 1'bx;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (if_valid_o) begin
        tv = cyc; rd = if_rdata_o; er = if_error_o; break;
      end
    end
    if (tv < 0) check("if_timeout", 64'(k), 64'h0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, tv, t2, tv2, w0, r0, v0, s0, f0, m0;
    logic [63:0] rd, rd2;
    logic er, er2;

    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_r_en", ram_r_en_o, 64'h0);
    check("rst_w_en", ram_w_en_o, 64'h0);
    check("rst_addr", ram_addr_o, 64'h0);
    check("rst_valid", {m_valid_o, if_valid_o}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset during the first access cycle of a write
    w0 = n_wen; v0 = n_mv;
    m_we = 1'b1; m_addr = 64'h80; m_wdata = 64'h55; m_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; m_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t1_wen", 64'(n_wen - w0), 64'h0);
    check("t1_valid", 64'(n_mv - v0), 64'h0);
    check("t1_mem80", mem[16], 64'hC0DE_0000_0000_0010);

    // 2: single read of 0x100
    r0 = n_ren; s0 = n_mst;
    mem_txn(1'b0, 64'h100, 64'h0, t, tv, rd, er);
    check("t2_lat", 64'(tv - t), 64'h3);
    check("t2_rdata", rd, 64'hDEAD_BEEF);
    check("t2_ren", 64'(n_ren - r0), 64'h2);
    check("t2_stall", 64'(n_mst - s0), 64'h3);

    // 3: single write of 0x1234 to 0x40
    w0 = n_wen;
    mem_txn(1'b1, 64'h40, 64'h1234, t, tv, rd, er);
    check("t3_wen", 64'(n_wen - w0), 64'h1);
    check("t3_wcyc", 64'(wen_cyc - t), 64'h2);
    check("t3_waddr", wen_addr, 64'h40);
    check("t3_wdata", wen_data, 64'h1234);
    check("t3_lat", 64'(tv - t), 64'h3);
    check("t3_rdata", rd, 64'h0);
    check("t3_mem40", mem[8], 64'h1234);

    // 4: simultaneous requests, MEM first
    f0 = n_fst;
    fork
      mem_txn(1'b0, 64'h200, 64'h0, t, tv, rd, er);
      fetch_txn(64'h0, t2, tv2, rd2, er2);
    join
    check("t4_m_lat", 64'(tv - t), 64'h3);
    check("t4_if_lat", 64'(tv2 - t2), 64'h7);
    check("t4_m_rdata", rd, 64'hC0DE_0000_0000_0040);
    check("t4_if_rdata", rd2, 64'hC0DE_0000_0000_0000);
    check("t4_if_stall", 64'(n_fst - f0), 64'h7);

    // 5: out-of-range read then a clean read
    mem_txn(1'b0, 64'h800, 64'h0, t, tv, rd, er);
    check("t5_err", 64'(er), 64'h1);
    mem_txn(1'b0, 64'h8, 64'h0, t, tv, rd, er);
    check("t5_noerr", 64'(er), 64'h0);
    check("t5_rdata", rd, 64'hC0DE_0000_0000_0001);

    // 6: constant MEM pressure with a waiting fetch
    own_q.delete();
    f0 = n_fv; m0 = n_mv;
    m_we = 1'b0; m_addr = 64'h10; m_req = 1'b1;
    if_addr = 64'h18; if_req = 1'b1;
    repeat (50) @(posedge clk);
    #1;
`ifdef DMEM_ARB_AGE_EN
    check("t6_count", 64'(own_q.size() >= 10), 64'h1);
    for (int i = 0; i < 10 && i < own_q.size(); i++) begin
      check("t6_owner", 64'(own_q[i]), 64'((i % 5) != 4));
    end
`else
    check("t6_no_fetch", 64'(n_fv - f0), 64'h0);
    check("t6_mem_cnt", 64'(n_mv - m0), 64'd12);
`endif
    m_req = 1'b0; if_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
